fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_fifo.sv | 87 ++++++++
 rtl/fetch_unit.sv | 73 +++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared definitions.
// Widths, opcode field location, opcode constants and FSM states.
package fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam int OP_MSB = 4;
    localparam int OP_LSB = 0;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_EOP    = 5'b00000;
    localparam logic [OP_W-1:0] OP_JMP    = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR_LO  = 5'b01100;
    localparam logic [OP_W-1:0] OP_BR_HI  = 5'b01111;
    localparam logic [OP_W-1:0] OP_BR_ALT = 5'b10001;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_eop(input logic [INSTR_W-1:0] w);
        return w[OP_MSB:OP_LSB] == OP_EOP;
    endfunction

    function automatic logic is_branch(input logic [INSTR_W-1:0] w);
        logic [OP_W-1:0] op;
        op = w[OP_MSB:OP_LSB];
        return ((op >= OP_BR_LO) && (op <= OP_BR_HI)) || (op == OP_BR_ALT);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with head/tail pointers.
// Flush empties it in one cycle and wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 40
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == FULL);
    assign data_o  = mem_q[head_q];

    // A push into a full queue is only legal alongside a pop.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer and occupancy, flush taking priority.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_pop) begin
                head_d = ptr_inc(head_q);
            end
            if (do_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Pointer and count registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[tail_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, RUN/HALT state machine and prefetch queue.
// Redirect flushes the queue and restarts fetch at the target.
module fetch_unit #(
    parameter int DEPTH = 2,
    parameter int PC_W  = fetch_unit_pkg::PC_W
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [PC_W-1:0] pm_addr,
    input  logic [31:0]     pm_data,
    output logic [31:0]     instr_out,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted
);

    localparam int IW = fetch_unit_pkg::INSTR_W;
    localparam int EW = PC_W + IW;

    fetch_unit_pkg::fetch_state_e state_q;

    logic [PC_W-1:0] pc_q;
    logic [EW-1:0]   fifo_dout;
    logic            fifo_valid;
    logic            fifo_full;
    logic            pop;
    logic            fetch;

    assign pop   = fifo_valid && instr_ready;
    assign fetch = (state_q == fetch_unit_pkg::ST_RUN) && !redirect
                   && (!fifo_full || pop);

    assign pm_addr     = pc_q;
    assign instr_valid = fifo_valid;
    assign instr_pc    = fifo_dout[EW-1:IW];
    assign instr_out   = fifo_dout[IW-1:0];
    assign halted      = (state_q == fetch_unit_pkg::ST_HALT);

    // PC and RUN/HALT control: reset, then redirect, then fetch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q    <= '0;
            state_q <= fetch_unit_pkg::ST_RUN;
        end else if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= fetch_unit_pkg::ST_RUN;
        end else if (fetch) begin
            pc_q <= pc_q + 1'b1;
            if (fetch_unit_pkg::is_eop(pm_data)) begin
                state_q <= fetch_unit_pkg::ST_HALT;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .flush_i (redirect),
        .push_i  (fetch),
        .pop_i   (pop),
        .data_i  ({pc_q, pm_data}),
        .data_o  (fifo_dout),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

endmodule
